// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_rd_arbiter                                                  |
// | Purpose  : Shares one AXI AR/R channel between the instruction fetch port  |
// |            (ARID 0) and the data read port (ARID 1). Fixed priority, data  |
// |            over inst; per-ID outstanding-read counters; R pass-through.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module axi_rd_arbiter #(
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data read port
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        wr_busy,
  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_AR_SEND = 1'b1
  } state_t;

  localparam logic [1:0] c_max_outst = 2'(MAX_OUTST);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [1:0]  r_cnt0;
  logic [1:0]  r_cnt1;

  logic        w_grant_data;
  logic        w_grant_inst;
  logic        w_grant;
  logic        w_dec0;
  logic        w_dec1;
  logic        w_unused_rd;

  // Arbitration and next-state: grants only from IDLE, data wins over inst.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_data = 1'b0;
    w_grant_inst = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (resetn) begin
          w_grant_data = data_req & ~wr_busy & (r_cnt1 < c_max_outst);
          w_grant_inst = ~w_grant_data & inst_req & (r_cnt0 < c_max_outst);
        end
        if (w_grant_data | w_grant_inst) begin
          w_state_nxt = S_AR_SEND;
        end
      end
      S_AR_SEND: begin
        // Handshake returns to IDLE; the next grant can only happen there.
        if (arready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_grant = w_grant_data | w_grant_inst;

  // A beat only retires a read if that ID actually has one in flight.
  assign w_dec0 = rvalid & rlast & ~rid[0] & (r_cnt0 != 2'd0);
  assign w_dec1 = rvalid & rlast &  rid[0] & (r_cnt1 != 2'd0);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // AR payload is captured on grant and held stable through AR_SEND.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner <= 1'b0;
      r_addr  <= 32'd0;
      r_size  <= 2'd0;
    end else if (w_grant) begin
      r_owner <= w_grant_data;
      r_addr  <= w_grant_data ? data_addr : inst_addr;
      r_size  <= w_grant_data ? data_size : inst_size;
    end
  end

  // Outstanding-read counters; simultaneous grant and retire cancel out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt0 <= 2'd0;
      r_cnt1 <= 2'd0;
    end else begin
      case ({w_grant_inst, w_dec0})
        2'b10:   r_cnt0 <= r_cnt0 + 2'd1;
        2'b01:   r_cnt0 <= r_cnt0 - 2'd1;
        default: r_cnt0 <= r_cnt0;
      endcase
      case ({w_grant_data, w_dec1})
        2'b10:   r_cnt1 <= r_cnt1 + 2'd1;
        2'b01:   r_cnt1 <= r_cnt1 - 2'd1;
        default: r_cnt1 <= r_cnt1;
      endcase
    end
  end

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;

  assign arid    = {3'b000, r_owner};
  assign araddr  = r_addr;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, r_size};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (r_state == S_AR_SEND);

  // R channel is always accepted and steered by the low ID bit.
  assign rready       = 1'b1;
  assign inst_data_ok = resetn & rvalid & ~rid[0];
  assign data_data_ok = resetn & rvalid &  rid[0];
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  // Response code and upper ID bits carry no meaning for this bridge.
  assign w_unused_rd = ^{rresp, rid[3:1]};

  a_r_inst_owned: assert property (@(posedge clk) disable iff (!resetn)
    (rvalid && rlast && !rid[0]) |-> (r_cnt0 != 2'd0));
  a_r_data_owned: assert property (@(posedge clk) disable iff (!resetn)
    (rvalid && rlast && rid[0]) |-> (r_cnt1 != 2'd0));
  a_one_addr_ok: assert property (@(posedge clk) disable iff (!resetn)
    !(inst_addr_ok && data_addr_ok));

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi_rd_arbiter                                               |
// | Purpose  : Directed scoreboard bench for axi_rd_arbiter.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axi_rd_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [1:0]  inst_size;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        wr_busy;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks;
  int failures;

  logic        exp_grant[$];
  logic [63:0] exp_ar[$];
  logic [32:0] exp_r[$];

  axi_rd_arbiter #(.MAX_OUTST(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .wr_busy(wr_busy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ar_exp(input logic id, input logic [31:0] a, input logic [1:0] s);
    return {6'b0, 3'b0, id, a, 1'b0, s, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic r_beat(input logic id, input logic [31:0] d);
    rvalid = 1'b1;
    rid    = {3'b000, id};
    rlast  = 1'b1;
    rdata  = d;
    exp_r.push_back({id, d});
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  // Monitor: pops expected grants, AR beats and R deliveries as the DUT shows them.
  always @(negedge clk) begin
    if (resetn) begin
      if (inst_addr_ok || data_addr_ok) begin
        check("addr_ok_exclusive", 64'(inst_addr_ok & data_addr_ok), 64'(0));
        if (exp_grant.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL grant_unexpected actual inst=%0b data=%0b required none t=%0t",
                   inst_addr_ok, data_addr_ok, $time);
        end else begin
          check("grant_owner", 64'(data_addr_ok), 64'(exp_grant.pop_front()));
        end
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ar_unexpected actual araddr=%0h required none t=%0t", araddr, $time);
        end else begin
          check("ar_payload",
                {6'b0, arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot},
                exp_ar.pop_front());
        end
      end
      if (inst_data_ok || data_data_ok) begin
        if (exp_r.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL r_unexpected actual inst=%0b data=%0b required none t=%0t",
                   inst_data_ok, data_data_ok, $time);
        end else begin
          logic [32:0] e;
          e = exp_r.pop_front();
          check("r_route", 64'({data_data_ok, inst_data_ok, inst_rdata}),
                64'({e[32], ~e[32], e[31:0]}));
          check("r_data_port", 64'(data_rdata), 64'(e[31:0]));
        end
      end
    end
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c000000; inst_size = 2'd2;
    data_req = 1'b0; data_addr = 32'd0; data_size = 2'd0; wr_busy = 1'b0;
    arready = 1'b1; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;

    // Reset held with a request pending
    repeat (2) @(negedge clk);
    check("rst_arvalid", 64'(arvalid), 64'(0));
    check("rst_inst_addr_ok", 64'(inst_addr_ok), 64'(0));
    check("rst_araddr", 64'(araddr), 64'(0));
    check("rst_arid", 64'(arid), 64'(0));
    check("rst_arsize", 64'(arsize), 64'(0));
    rvalid = 1'b1; rlast = 1'b1;
    #1 check("rst_inst_data_ok", 64'(inst_data_ok), 64'(0));
    step();
    rvalid = 1'b0; rlast = 1'b0; inst_req = 1'b0; resetn = 1'b1;
    @(negedge clk);
    check("idle_arvalid", 64'(arvalid), 64'(0));
    check("rready_const", 64'(rready), 64'(1));

    // Single fetch
    step();
    inst_req = 1'b1;
    exp_grant.push_back(1'b0); exp_ar.push_back(ar_exp(1'b0, 32'h1c000000, 2'd2));
    @(negedge clk);
    check("t2_addr_ok_cycle0", 64'(inst_addr_ok), 64'(1));
    step();
    inst_req = 1'b0;
    @(negedge clk);
    check("t2_arvalid_cycle1", 64'(arvalid), 64'(1));
    step();
    r_beat(1'b0, 32'h02800c0c);

    // Contention: data first, inst on the next IDLE
    inst_req = 1'b1; data_req = 1'b1;
    inst_addr = 32'h1c001000; data_addr = 32'h1c001000; data_size = 2'd2;
    exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
    exp_ar.push_back(ar_exp(1'b1, 32'h1c001000, 2'd2));
    exp_ar.push_back(ar_exp(1'b0, 32'h1c001000, 2'd2));
    @(negedge clk);
    check("t3_data_first", 64'(data_addr_ok), 64'(1));
    step();
    data_req = 1'b0;
    @(negedge clk);
    check("t3_no_grant_in_ar", 64'(inst_addr_ok), 64'(0));
    step();
    @(negedge clk);
    check("t3_inst_next", 64'(inst_addr_ok), 64'(1));
    step();
    inst_req = 1'b0;
    step();
    r_beat(1'b0, 32'h11112222);
    r_beat(1'b1, 32'h33334444);

    // wr_busy blocks data reads only
    inst_addr = 32'h1c000040; data_addr = 32'h80000013; data_size = 2'd0;
    wr_busy = 1'b1; inst_req = 1'b1; data_req = 1'b1;
    exp_grant.push_back(1'b0); exp_ar.push_back(ar_exp(1'b0, 32'h1c000040, 2'd2));
    @(negedge clk);
    check("t4_busy_blocks_data", 64'(data_addr_ok), 64'(0));
    step();
    inst_req = 1'b0;
    step();
    @(negedge clk);
    check("t4_still_blocked", 64'(data_addr_ok), 64'(0));
    step();
    wr_busy = 1'b0;
    exp_grant.push_back(1'b1); exp_ar.push_back(ar_exp(1'b1, 32'h80000013, 2'd0));
    @(negedge clk);
    check("t4_data_after_busy", 64'(data_addr_ok), 64'(1));
    step();
    data_req = 1'b0;
    step();
    r_beat(1'b1, 32'h55556666);
    r_beat(1'b0, 32'h77778888);

    // Outstanding limit on ID 0
    inst_req = 1'b1; inst_addr = 32'h1c000100;
    exp_grant.push_back(1'b0); exp_ar.push_back(ar_exp(1'b0, 32'h1c000100, 2'd2));
    @(negedge clk);
    step(); inst_addr = 32'h1c000104;
    step();
    exp_grant.push_back(1'b0); exp_ar.push_back(ar_exp(1'b0, 32'h1c000104, 2'd2));
    @(negedge clk);
    step(); inst_addr = 32'h1c000108;
    step();
    @(negedge clk);
    check("t5_limit_stall", 64'(inst_addr_ok), 64'(0));
    step();
    @(negedge clk);
    check("t5_limit_stall2", 64'(inst_addr_ok), 64'(0));
    step();
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b1; rdata = 32'hA0A0A0A0;
    exp_r.push_back({1'b0, 32'hA0A0A0A0});
    @(negedge clk);
    check("t5_stall_during_r", 64'(inst_addr_ok), 64'(0));
    step();
    // Grant and retire in the same cycle
    rdata = 32'hB1B1B1B1;
    exp_r.push_back({1'b0, 32'hB1B1B1B1});
    exp_grant.push_back(1'b0); exp_ar.push_back(ar_exp(1'b0, 32'h1c000108, 2'd2));
    @(negedge clk);
    check("t5_regrant", 64'(inst_addr_ok), 64'(1));
    step();
    rvalid = 1'b0; rlast = 1'b0; inst_addr = 32'h1c00010c;
    step();
    exp_grant.push_back(1'b0); exp_ar.push_back(ar_exp(1'b0, 32'h1c00010c, 2'd2));
    @(negedge clk);
    check("t5_one_slot_left", 64'(inst_addr_ok), 64'(1));
    step(); inst_addr = 32'h1c000110;
    step();
    @(negedge clk);
    check("t5_inc_dec_held", 64'(inst_addr_ok), 64'(0));
    inst_req = 1'b0;
    step();
    r_beat(1'b0, 32'hC2C2C2C2);
    r_beat(1'b0, 32'hD3D3D3D3);

    // AR backpressure, then async reset mid-request
    arready = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c002000;
    exp_grant.push_back(1'b0);
    @(negedge clk);
    step();
    inst_addr = 32'h1c002004; data_req = 1'b1; data_addr = 32'h80000100;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("t6_arvalid_stable", 64'(arvalid), 64'(1));
      check("t6_payload_stable", {6'b0, arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot},
            ar_exp(1'b0, 32'h1c002000, 2'd2));
      check("t6_no_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'(0));
      if (c < 3) step();
    end
    #1 resetn = 1'b0;
    #1;
    check("t6_rst_arvalid", 64'(arvalid), 64'(0));
    check("t6_rst_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'(0));
    check("t6_rst_araddr", 64'(araddr), 64'(0));
    step(); step();
    inst_req = 1'b0; data_req = 1'b0; arready = 1'b1; resetn = 1'b1;
    step();
    inst_req = 1'b1; inst_addr = 32'h1c003000;
    exp_grant.push_back(1'b0); exp_ar.push_back(ar_exp(1'b0, 32'h1c003000, 2'd2));
    @(negedge clk);
    check("t6_post_rst_grant", 64'(inst_addr_ok), 64'(1));
    step();
    inst_req = 1'b0;
    step();
    r_beat(1'b0, 32'hE4E4E4E4);
    step(); step();

    check("q_grant_empty", 64'(exp_grant.size()), 64'(0));
    check("q_ar_empty", 64'(exp_ar.size()), 64'(0));
    check("q_r_empty", 64'(exp_r.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
